// File: rtl/sram_controller.sv
// MEM-stage controller for a 32-bit asynchronous SRAM: multi-cycle load/store with pipeline stall.
// Optional misaligned-access trap is compiled in when SRAM_ALIGN_CHECK_EN is defined.
module sram_controller #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            memOp_i,
    input  logic [31:0]           physicalAddr_i,
    input  logic [31:0]           storeData_i,
    output logic [31:0]           ramData_o,
    output logic                  stall_o,
    output logic                  addrErr_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i,
    output logic                  sram_data_oe_o,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic [3:0]            sram_be_n_o
);
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LB  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd3;
    localparam logic [3:0] OP_LH  = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd7;
    localparam logic [3:0] OP_SH  = 4'd8;

    localparam int unsigned MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_WAIT - 1);
    localparam logic [CNT_W-1:0] WRITE_HOLD = CNT_W'(WRITE_WAIT - 2);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [1:0]       lo_q;

    logic        op_load;
    logic        op_store;
    logic        op_valid;
    logic [31:0] st_data;
    logic [3:0]  st_be_n;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        unused_addr_bits;

    assign op_load  = (memOp_i >= OP_LW) && (memOp_i <= OP_LHU);
    assign op_store = (memOp_i >= OP_SW) && (memOp_i <= OP_SH);
    assign op_valid = op_load | op_store;
    assign unused_addr_bits = ^physicalAddr_i[31:ADDR_WIDTH+2];

`ifdef SRAM_ALIGN_CHECK_EN
    logic misaligned;
    logic addr_err_q;

    always_comb begin
        case (memOp_i)
            OP_LW, OP_SW:         misaligned = physicalAddr_i[1:0] != 2'b00;
            OP_LH, OP_LHU, OP_SH: misaligned = physicalAddr_i[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign addrErr_o = addr_err_q;
`else
    assign addrErr_o = 1'b0;
`endif

    always_comb begin
        st_data = storeData_i;
        st_be_n = '0;
        case (memOp_i)
            OP_SH: begin
                st_data = {2{storeData_i[15:0]}};
                st_be_n = physicalAddr_i[1] ? 4'b0011 : 4'b1100;
            end
            OP_SB: begin
                st_data = {4{storeData_i[7:0]}};
                st_be_n = ~(4'b0001 << physicalAddr_i[1:0]);
            end
            default: ;
        endcase
    end

    // Extraction sits in front of the result register, so ramData_o holds the
    // extended value of the word sampled on the last READ cycle.
    always_comb begin
        case (lo_q)
            2'd0:    ld_byte = sram_rdata_i[7:0];
            2'd1:    ld_byte = sram_rdata_i[15:8];
            2'd2:    ld_byte = sram_rdata_i[23:16];
            default: ld_byte = sram_rdata_i[31:24];
        endcase
        ld_half = lo_q[1] ? sram_rdata_i[31:16] : sram_rdata_i[15:0];
        case (op_q)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'h0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'h0, ld_half};
            default: ld_val = sram_rdata_i;
        endcase
    end

    always_comb begin
        case (state)
            IDLE:        stall_o = op_valid;
            READ, WRITE: stall_o = 1'b1;
            default:     stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            op_q           <= '0;
            lo_q           <= '0;
            ramData_o      <= '0;
            sram_addr_o    <= '0;
            sram_wdata_o   <= '0;
            sram_data_oe_o <= 1'b0;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= '1;
`ifdef SRAM_ALIGN_CHECK_EN
            addr_err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_q <= memOp_i;
                        lo_q <= physicalAddr_i[1:0];
                        cnt  <= '0;
`ifdef SRAM_ALIGN_CHECK_EN
                        if (misaligned) begin
                            state      <= DONE;
                            addr_err_q <= 1'b1;
                            if (op_load)
                                ramData_o <= '0;
                        end else
`endif
                        if (op_load) begin
                            state          <= READ;
                            sram_addr_o    <= physicalAddr_i[ADDR_WIDTH+1:2];
                            sram_be_n_o    <= '0;
                            sram_data_oe_o <= 1'b0;
                            sram_ce_n_o    <= 1'b0;
                            sram_oe_n_o    <= 1'b0;
                        end else begin
                            state          <= WRITE;
                            sram_addr_o    <= physicalAddr_i[ADDR_WIDTH+1:2];
                            sram_wdata_o   <= st_data;
                            sram_be_n_o    <= st_be_n;
                            sram_data_oe_o <= 1'b1;
                            sram_ce_n_o    <= 1'b0;
                            sram_we_n_o    <= 1'b0;
                        end
                    end
                end
                READ: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == READ_LAST) begin
                        state       <= DONE;
                        ramData_o   <= ld_val;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_be_n_o <= '1;
                    end
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    // we_n rises one cycle early so addr/data/be are held past the write pulse
                    if (cnt == WRITE_HOLD)
                        sram_we_n_o <= 1'b1;
                    if (cnt == WRITE_LAST) begin
                        state          <= DONE;
                        sram_ce_n_o    <= 1'b1;
                        sram_we_n_o    <= 1'b1;
                        sram_data_oe_o <= 1'b0;
                        sram_be_n_o    <= '1;
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef SRAM_ALIGN_CHECK_EN
                    addr_err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: driver pushes model expectations, a monitor
// checks each completed access (DONE cycle) against them; honours SRAM_ALIGN_CHECK_EN.
module tb_sram_controller;
    localparam int unsigned AW = 20;
    localparam int unsigned RW = 2;
    localparam int unsigned WW = 2;
`ifdef SRAM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif
    localparam logic [3:0] LW = 4'd1, LB = 4'd2, LBU = 4'd3, LH = 4'd4, LHU = 4'd5;
    localparam logic [3:0] SW = 4'd6, SB = 4'd7, SH = 4'd8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    memOp_i;
    logic [31:0]   physicalAddr_i;
    logic [31:0]   storeData_i;
    logic [31:0]   ramData_o;
    logic          stall_o;
    logic          addrErr_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_i;
    logic          sram_data_oe_o;
    logic          sram_ce_n_o;
    logic          sram_oe_n_o;
    logic          sram_we_n_o;
    logic [3:0]    sram_be_n_o;

    always #5 clk = ~clk;

    sram_controller #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .clk(clk), .rst(rst), .memOp_i(memOp_i), .physicalAddr_i(physicalAddr_i),
        .storeData_i(storeData_i), .ramData_o(ramData_o), .stall_o(stall_o),
        .addrErr_o(addrErr_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i), .sram_data_oe_o(sram_data_oe_o),
        .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
        .sram_be_n_o(sram_be_n_o)
    );

    // External SRAM device: 16 words, aliased on the low word-address bits
    logic [31:0] sram_mem [16];
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (pre_en)
            sram_mem[pre_idx] <= pre_val;
        else if (sram_ce_n_o === 1'b0 && sram_we_n_o === 1'b0)
            for (int b = 0; b < 4; b++)
                if (!sram_be_n_o[b])
                    sram_mem[sram_addr_o[3:0]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
    end

    assign sram_rdata_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o[3:0]] : 32'h0;

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] model_rd;

    typedef struct {
        logic [31:0]   rd;
        logic [AW-1:0] addr;
        logic [3:0]    be_n;
        logic [31:0]   wdata;
        logic          store;
        logic          err;
        int unsigned   stall;
        int unsigned   ce;
        int unsigned   oe;
        int unsigned   we;
        int unsigned   doe;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_misaligned(input logic [3:0] op, input logic [31:0] a);
        bit word_op;
        bit half_op;
        word_op = (op == LW) || (op == SW);
        half_op = (op == LH) || (op == LHU) || (op == SH);
        return ALIGN_CHK && ((word_op && (a[1:0] != 2'b00)) || (half_op && a[0]));
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lo,
                                                 input logic [31:0] w);
        logic [31:0] v;
        v = w;
        if (op == LB || op == LBU) begin
            v = (w >> (8 * lo)) & 32'h0000_00FF;
            if (op == LB && v[7]) v = v | 32'hFFFF_FF00;
        end else if (op == LH || op == LHU) begin
            v = (w >> (16 * lo[1])) & 32'h0000_FFFF;
            if (op == LH && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic preload(input int unsigned idx, input logic [31:0] v);
        ref_mem[idx] = v;
        pre_idx = 4'(idx);
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    // Called just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
        exp_t        e;
        int unsigned idx;
        bit          is_ld;
        bit          is_st;
        bit          en;
        bit          done;
        int unsigned n;
        logic [7:0]  v;
        idx   = int'(a[5:2]);
        is_ld = (op >= LW) && (op <= LHU);
        is_st = (op >= SW) && (op <= SH);
        rd    = '0;
        memOp_i        = op;
        physicalAddr_i = a;
        storeData_i    = d;
        if (!is_ld && !is_st) begin
            @(negedge clk);
            check("idle_no_stall", 32'(stall_o), 32'd0);
            @(posedge clk); #1;
            memOp_i = 4'd0;
        end else begin
            e.addr  = a[AW+1:2];
            e.be_n  = 4'hF;
            e.wdata = '0;
            e.store = is_st;
            e.err   = 1'b0;
            if (model_misaligned(op, a)) begin
                e.err = 1'b1; e.stall = 1; e.ce = 0; e.oe = 0; e.we = 0; e.doe = 0;
                if (is_ld) model_rd = '0;
            end else if (is_ld) begin
                model_rd = load_extract(op, a[1:0], ref_mem[idx]);
                e.be_n = 4'h0; e.stall = 1 + RW; e.ce = RW; e.oe = RW; e.we = 0; e.doe = 0;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (op == SW) begin
                        en = 1'b1; v = d[8*b +: 8];
                    end else if (op == SH) begin
                        en = (b / 2) == int'(a[1]); v = d[8*(b % 2) +: 8];
                    end else begin
                        en = b == int'(a[1:0]); v = d[7:0];
                    end
                    e.wdata[8*b +: 8] = v;
                    e.be_n[b] = !en;
                    if (en) ref_mem[idx][8*b +: 8] = v;
                end
                e.stall = 1 + WW; e.ce = WW; e.oe = 0; e.we = WW - 1; e.doe = WW;
            end
            e.rd = model_rd;
            sb_q.push_back(e);
            done = 1'b0;
            n = 0;
            while (!done && n < 32) begin
                @(negedge clk);
                if (!stall_o) done = 1'b1;
                n++;
            end
            check("access_completes", 32'(done), 32'd1);
            rd = ramData_o;
            @(posedge clk); #1;
            memOp_i = 4'd0;
        end
    endtask

    // Monitor: accumulates bus activity over stall cycles and scores each DONE cycle
    int unsigned   acc_stall, acc_ce, acc_oe, acc_we, acc_doe;
    logic [AW-1:0] cap_addr;
    logic [3:0]    cap_be;
    logic [31:0]   cap_wdata;
    logic          bus_changed;

    initial begin
        exp_t e;
        acc_stall = 0; acc_ce = 0; acc_oe = 0; acc_we = 0; acc_doe = 0; bus_changed = 1'b0;
        cap_addr = '0; cap_be = '0; cap_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_stall = 0; acc_ce = 0; acc_oe = 0; acc_we = 0; acc_doe = 0;
                bus_changed = 1'b0;
            end else if (stall_o) begin
                acc_stall++;
                if (!sram_ce_n_o) begin
                    if (acc_ce == 0) begin
                        cap_addr = sram_addr_o; cap_be = sram_be_n_o; cap_wdata = sram_wdata_o;
                    end else if (cap_addr !== sram_addr_o || cap_be !== sram_be_n_o ||
                                 cap_wdata !== sram_wdata_o) begin
                        bus_changed = 1'b1;
                    end
                    acc_ce++;
                end
                if (!sram_oe_n_o) acc_oe++;
                if (!sram_we_n_o) acc_we++;
                if (sram_data_oe_o) acc_doe++;
            end else if (acc_stall > 0) begin
                check("done_has_expectation", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("stall_cycles", 32'(acc_stall), 32'(e.stall));
                    check("ce_low_cycles", 32'(acc_ce), 32'(e.ce));
                    check("oe_low_cycles", 32'(acc_oe), 32'(e.oe));
                    check("we_low_cycles", 32'(acc_we), 32'(e.we));
                    check("data_oe_cycles", 32'(acc_doe), 32'(e.doe));
                    if (e.ce > 0) begin
                        check("sram_addr", 32'(cap_addr), 32'(e.addr));
                        check("be_n", 32'(cap_be), 32'(e.be_n));
                        check("bus_stable", 32'(bus_changed), 32'd0);
                        if (e.store) check("wdata", cap_wdata, e.wdata);
                    end
                    check("done_ce_n", 32'(sram_ce_n_o), 32'd1);
                    check("done_oe_n", 32'(sram_oe_n_o), 32'd1);
                    check("done_we_n", 32'(sram_we_n_o), 32'd1);
                    check("done_data_oe", 32'(sram_data_oe_o), 32'd0);
                    check("ramData", ramData_o, e.rd);
                    check("addrErr", 32'(addrErr_o), 32'(e.err));
                end
                acc_stall = 0; acc_ce = 0; acc_oe = 0; acc_we = 0; acc_doe = 0;
                bus_changed = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  op;
        rst = 1'b1; memOp_i = '0; physicalAddr_i = '0; storeData_i = '0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0; model_rd = '0;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 16; i++) preload(i, $urandom());
        rst = 1'b0;
        @(negedge clk);
        check("rst_ramData", ramData_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_addrErr", 32'(addrErr_o), 32'd0);
        check("rst_addr", 32'(sram_addr_o), 32'd0);
        check("rst_wdata", sram_wdata_o, 32'h0);
        check("rst_data_oe", 32'(sram_data_oe_o), 32'd0);
        check("rst_ce_n", 32'(sram_ce_n_o), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n_o), 32'd1);
        check("rst_we_n", 32'(sram_we_n_o), 32'd1);
        check("rst_be_n", 32'(sram_be_n_o), 32'hF);
        @(posedge clk); #1;

        do_op(SW, 32'h0000_0010, 32'hDEAD_BEEF, rd);
        do_op(LW, 32'h0000_0010, 32'h0, rd);
        check("lw_deadbeef", rd, 32'hDEAD_BEEF);
        do_op(SB, 32'h0000_0013, 32'h0000_00A5, rd);
        check("sb_keeps_ramData", rd, 32'hDEAD_BEEF);
        preload(4, 32'hA500_0000);
        do_op(LB, 32'h0000_0013, 32'h0, rd);
        check("lb_sign", rd, 32'hFFFF_FFA5);
        do_op(LBU, 32'h0000_0013, 32'h0, rd);
        check("lbu_zero", rd, 32'h0000_00A5);
        preload(4, 32'h8001_FFFF);
        do_op(LH, 32'h0000_0012, 32'h0, rd);
        check("lh_sign", rd, 32'hFFFF_8001);
        do_op(LHU, 32'h0000_0012, 32'h0, rd);
        check("lhu_zero", rd, 32'h0000_8001);
        do_op(SH, 32'h0000_0012, 32'h0000_1234, rd);

        // Reset during the second READ cycle of a load
        memOp_i = LW; physicalAddr_i = 32'h0000_0010;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; memOp_i = 4'd0; model_rd = '0;
        @(negedge clk);
        check("abort_ce_n", 32'(sram_ce_n_o), 32'd1);
        check("abort_oe_n", 32'(sram_oe_n_o), 32'd1);
        check("abort_we_n", 32'(sram_we_n_o), 32'd1);
        check("abort_stall", 32'(stall_o), 32'd0);
        check("abort_ramData", ramData_o, 32'h0);
        @(posedge clk); #1;
        do_op(LW, 32'h0000_0010, 32'h0, rd);
        check("lw_after_abort", rd, 32'h1234_FFFF);

        preload(4, 32'hCAFE_F00D);
        do_op(LW, 32'h0000_0011, 32'h0, rd);
        check("lw_unaligned", rd, ALIGN_CHK ? 32'h0 : 32'hCAFE_F00D);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 9));
            if (op == 4'd9) op = 4'($urandom_range(9, 15));
            do_op(op, $urandom(), $urandom(), rd);
            if (op >= LW && op <= SH) check("rand_ramData", rd, model_rd);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the MEM-stage address-translation block.
- Consumes its memory operation code, physical address and store data, and runs a multi-cycle access on the 32-bit asynchronous external SRAM.
- Returns extended load data and holds the pipeline with a stall until the access finishes.

Parameters:
ADDR_WIDTH, 20, SRAM word-address width; sram_addr_o = physicalAddr_i[ADDR_WIDTH+1:2]
READ_WAIT, 2, cycles spent in READ state (>=1)
WRITE_WAIT, 2, cycles spent in WRITE state (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
memOp_i  input  4  0=none,1=LW,2=LB,3=LBU,4=LH,5=LHU,6=SW,7=SB,8=SH; 9-15 treated as none
physicalAddr_i  input  32  byte address
storeData_i  input  32  store data (low byte/half used for SB/SH)
ramData_o  output  32  extended load result, valid in DONE and held until next load completes
stall_o  output  1  pipeline hold request
addrErr_o  output  1  misaligned-access flag (see Optional Feature)
sram_addr_o  output  ADDR_WIDTH  SRAM word address
sram_wdata_o  output  32  SRAM write data
sram_rdata_i  input  32  SRAM read data
sram_data_oe_o  output  1  1 = drive data bus (tristate enable for top level)
sram_ce_n_o  output  1  chip enable, active low
sram_oe_n_o  output  1  output enable, active low
sram_we_n_o  output  1  write enable, active low
sram_be_n_o  output  4  byte enables, active low, lane i = bits[8i+7:8i]

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, counter=0, ramData_o=0, sram_addr_o=0, sram_wdata_o=0, sram_data_oe_o=0, ce_n/oe_n/we_n=1, be_n=4'b1111, addrErr_o=0.
- Reset mid-access: aborts on the next edge. All strobes are inactive from that edge.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Valid op: latch addr/op/data; go to READ (ops 1-5) or WRITE (ops 6-8); counter=0.
  - Otherwise stay in IDLE.
- READ:
  - ce_n=0, oe_n=0, be_n=0000, data_oe=0.
  - Stay READ_WAIT cycles; on the last cycle register sram_rdata_i, then go to DONE.
- WRITE:
  - ce_n=0, data_oe=1.
  - we_n=0 on every WRITE cycle except the last (data hold cycle), where we_n=1 and addr/data/be are unchanged.
  - After WRITE_WAIT cycles go to DONE.
- DONE: all strobes inactive; go to IDLE unconditionally. memOp_i is ignored in DONE (it is the same instruction).
- stall_o (combinational):
  - 1 in IDLE when memOp_i is valid.
  - 1 in READ and WRITE.
  - 0 in DONE and in IDLE when there is no op.
  - Total stall cycles: load = 1+READ_WAIT, store = 1+WRITE_WAIT.
- Store lanes:
  - SW: be_n=0000, data=storeData_i.
  - SH: data={2{storeData_i[15:0]}}; be_n=1100 if addr[1]=0, else 0011.
  - SB: data={4{storeData_i[7:0]}}; be_n clears only bit addr[1:0].
- Load extract, from the registered word:
  - LW returns the whole word.
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- ramData_o is updated only when a load completes; stores leave it unchanged.
- Back-to-back memory ops: DONE -> IDLE -> new access. There is one idle cycle between accesses, and the new op stalls again in IDLE.

Optional Feature:
- Macro SRAM_ALIGN_CHECK_EN.
- Defined:
  - A misaligned op goes IDLE -> DONE with no SRAM strobes asserted. Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
  - It stalls 1 cycle.
  - addrErr_o=1 for that DONE cycle only.
  - ramData_o=0 for a misaligned load.
- Undefined:
  - Low address bits are ignored for word accesses (and addr[0] for halves); the access proceeds normally.
  - addrErr_o is tied 0.

Test Plan:
- Reset with all outputs checked, then SW addr 0x00000010 data 0xDEADBEEF -> sram_addr_o=4, be_n=0000, we_n low exactly 1 cycle (WRITE_WAIT=2), stall_o high 3 cycles.
- LW 0x00000010 with sram_rdata_i=0xDEADBEEF -> ramData_o=0xDEADBEEF in DONE, oe_n low 2 cycles, stall_o high 3 cycles.
- SB addr 0x13 data 0x000000A5 -> wdata=0xA5A5A5A5, be_n=0111; then LB 0x13 on word 0xA5000000 -> 0xFFFFFFA5; LBU -> 0x000000A5.
- LH 0x12 on word 0x8001FFFF -> 0xFFFF8001; LHU -> 0x00008001; SH 0x12 data 0x1234 -> be_n=0011, wdata=0x12341234.
- Assert rst in the second READ cycle -> next edge all strobes inactive, stall_o=0, ramData_o=0; a subsequent LW completes normally.
- With SRAM_ALIGN_CHECK_EN: LW 0x00000011 -> no ce_n pulse, stall_o 1 cycle, addrErr_o=1 one cycle, ramData_o=0. Without the macro: a normal access to word 4.
